// File: rtl/spi_reg_ctrl_if.sv
// Byte-side handshake between the SPI slave shifter and the
// register controller: frame markers, received byte, next byte.
interface spi_reg_ctrl_if;
    logic       frame_start;
    logic       frame_end;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;

    modport master (
        output frame_start, frame_end, rx_valid, rx_byte,
        input  tx_byte
    );

    modport slave (
        input  frame_start, frame_end, rx_valid, rx_byte,
        output tx_byte
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI command/register controller: decodes the command byte,
// sequences register writes/reads and supplies MISO bytes.
module spi_reg_ctrl #(
    parameter int         NUM_REGS = 8,
    parameter logic [7:0] DEV_ID   = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_reg_ctrl_if.slave           bus,
    output logic [8*NUM_REGS-1:0]   reg_q,
    output logic                    wr_stb,
    output logic [5:0]              wr_addr,
    output logic [7:0]              wr_data,
    output logic                    err
);

    typedef enum logic [2:0] {
        IDLE, CMD, WDATA, RDATA, DRAIN
    } state_t;

    state_t state, state_nx;

    logic [5:0] addr;
    logic       ai;
    logic [3:0] frame_cnt;
    logic [7:0] tx_q;
    logic [7:0] status;
    logic [7:0] rd_val;
    logic [5:0] rd_a;
    logic [8*(NUM_REGS-1)-1:0] rf;

    logic ld_cmd, wr_en, rd_en, inc, tx_dev, tx_clr;

    function automatic logic oor(input logic [5:0] a);
        return int'(a) >= NUM_REGS;
    endfunction

    assign status      = {err, 3'b000, frame_cnt};
    assign reg_q       = {rf, status};
    assign bus.tx_byte = tx_q;

    // Read mux: status at 0, register file in range, zero beyond.
    always_comb begin
        rd_val = 8'h00;
        if (rd_a == 6'd0)
            rd_val = status;
        else if (!oor(rd_a))
            rd_val = rf[8*(int'(rd_a)-1) +: 8];
    end

    // Next-state and per-cycle action decode.
    always_comb begin
        state_nx = state;
        ld_cmd   = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        rd_a     = addr;
        inc      = 1'b0;
        tx_dev   = 1'b0;
        tx_clr   = 1'b0;
        if (bus.frame_start) begin
            state_nx = CMD;
            tx_dev   = 1'b1;
        end else begin
            unique case (state)
                IDLE: ;
                CMD: if (bus.rx_valid) begin
                    ld_cmd = 1'b1;
                    if (bus.rx_byte[7]) begin
                        state_nx = WDATA;
                    end else begin
                        state_nx = RDATA;
                        rd_en    = 1'b1;
                        rd_a     = bus.rx_byte[5:0];
                    end
                end
                WDATA: if (bus.rx_valid) begin
                    wr_en = 1'b1;
                    if (ai) begin
                        inc = 1'b1;
                    end else begin
                        state_nx = DRAIN;
                        tx_clr   = 1'b1;
                    end
                end
                RDATA: if (bus.rx_valid) begin
                    if (ai) begin
                        inc   = 1'b1;
                        rd_en = 1'b1;
                        rd_a  = addr + 6'd1;
                    end else begin
                        state_nx = DRAIN;
                        tx_clr   = 1'b1;
                    end
                end
                DRAIN: ;
                default: state_nx = IDLE;
            endcase
            if (bus.frame_end) begin
                state_nx = IDLE;
                tx_clr   = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Address pointer, auto-increment flag and MISO byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= 6'd0;
            ai   <= 1'b0;
            tx_q <= 8'h00;
        end else begin
            if (ld_cmd) begin
                addr <= bus.rx_byte[5:0];
                ai   <= bus.rx_byte[6];
            end else if (inc) begin
                addr <= addr + 6'd1;
            end
            if (tx_dev)      tx_q <= DEV_ID;
            else if (tx_clr) tx_q <= 8'h00;
            else if (rd_en)  tx_q <= rd_val;
        end
    end

    // Sticky error: a status read clears it, range errors set it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            if (rd_en && rd_a == 6'd0)
                err <= 1'b0;
            if ((rd_en && oor(rd_a)) || (wr_en && oor(addr)))
                err <= 1'b1;
        end
    end

    // Write strobe and register file; address 0 is read-only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_stb  <= 1'b0;
            wr_addr <= 6'd0;
            wr_data <= 8'h00;
            rf      <= '0;
        end else begin
            wr_stb <= wr_en && addr != 6'd0 && !oor(addr);
            if (wr_en && addr != 6'd0 && !oor(addr)) begin
                wr_addr <= addr;
                wr_data <= bus.rx_byte;
            end
            for (int i = 1; i < NUM_REGS; i++)
                if (wr_en && int'(addr) == i)
                    rf[8*(i-1) +: 8] <= bus.rx_byte;
        end
    end

    // Frame counter shown in the status register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               frame_cnt <= 4'd0;
        else if (bus.frame_start) frame_cnt <= frame_cnt + 4'd1;
    end

endmodule
